// File: rtl/cellrv32_xbus_arbiter.sv
// rtl/cellrv32_xbus_arbiter.sv - two-host (data/instruction) to single downstream bus arbiter
// Each host owns a one-deep pending buffer; grants go fixed-priority (A) or round-robin.
module cellrv32_xbus_arbiter #(
    parameter logic RR_EN = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] a_addr_i,
    input  logic        a_rden_i,
    input  logic        a_wren_i,
    input  logic [3:0]  a_ben_i,
    input  logic [31:0] a_data_i,
    input  logic        a_src_i,
    input  logic        a_priv_i,
    output logic [31:0] a_data_o,
    output logic        a_ack_o,
    output logic        a_err_o,

    input  logic [31:0] b_addr_i,
    input  logic        b_rden_i,
    input  logic        b_wren_i,
    input  logic [3:0]  b_ben_i,
    input  logic [31:0] b_data_i,
    input  logic        b_src_i,
    input  logic        b_priv_i,
    output logic [31:0] b_data_o,
    output logic        b_ack_o,
    output logic        b_err_o,

    output logic [31:0] x_addr_o,
    output logic [31:0] x_data_o,
    output logic [3:0]  x_ben_o,
    output logic        x_rden_o,
    output logic        x_wren_o,
    output logic        x_src_o,
    output logic        x_priv_o,
    input  logic [31:0] x_data_i,
    input  logic        x_ack_i,
    input  logic        x_err_i,
    input  logic        x_tmo_i,

    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  ben;
        logic [31:0] wdata;
        logic        src;
        logic        priv;
    } req_t;

    state_t state;
    req_t   buf_a;
    req_t   buf_b;
    req_t   req_a;
    req_t   req_b;
    req_t   gnt_req;
    logic   pend_a;
    logic   pend_b;
    logic   last_b;

    logic   resp;
    logic   done_a;
    logic   done_b;
    logic   arb;
    logic   pick_a;
    logic   pick_b;
    logic   take_a;
    logic   take_b;

    // A set rden+wren pair is captured as a write.
    assign req_a = {a_wren_i, a_addr_i, a_ben_i, a_data_i, a_src_i, a_priv_i};
    assign req_b = {b_wren_i, b_addr_i, b_ben_i, b_data_i, b_src_i, b_priv_i};

    assign resp   = x_ack_i | x_err_i | x_tmo_i;
    assign done_a = (state == BUSY_A) & resp;
    assign done_b = (state == BUSY_B) & resp;
    assign arb    = (state == IDLE) | done_a | done_b;

    // With both pending, round-robin hands the bus to whoever was not served last.
    assign pick_a  = pend_a & (~pend_b | ~RR_EN | last_b);
    assign pick_b  = pend_b & ~pick_a;
    assign gnt_req = pick_a ? buf_a : buf_b;

    // A host may queue its next access in the very cycle its current one completes.
    assign take_a = (a_rden_i | a_wren_i) & ((~pend_a & (state != BUSY_A)) | done_a);
    assign take_b = (b_rden_i | b_wren_i) & ((~pend_b & (state != BUSY_B)) | done_b);

    assign a_err_o  = (state == BUSY_A) & (x_err_i | x_tmo_i);
    assign a_ack_o  = (state == BUSY_A) & x_ack_i & ~x_err_i & ~x_tmo_i;
    assign a_data_o = a_ack_o ? x_data_i : 32'h0;

    assign b_err_o  = (state == BUSY_B) & (x_err_i | x_tmo_i);
    assign b_ack_o  = (state == BUSY_B) & x_ack_i & ~x_err_i & ~x_tmo_i;
    assign b_data_o = b_ack_o ? x_data_i : 32'h0;

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            pend_a   <= 1'b0;
            pend_b   <= 1'b0;
            buf_a    <= '0;
            buf_b    <= '0;
            last_b   <= 1'b1;
            x_addr_o <= 32'h0;
            x_data_o <= 32'h0;
            x_ben_o  <= 4'h0;
            x_rden_o <= 1'b0;
            x_wren_o <= 1'b0;
            x_src_o  <= 1'b0;
            x_priv_o <= 1'b0;
        end else begin
            x_rden_o <= 1'b0;
            x_wren_o <= 1'b0;

            if (arb) begin
                if (pick_a || pick_b) begin
                    state    <= pick_a ? BUSY_A : BUSY_B;
                    last_b   <= pick_b;
                    x_addr_o <= gnt_req.addr;
                    x_data_o <= gnt_req.wdata;
                    x_ben_o  <= gnt_req.ben;
                    x_src_o  <= gnt_req.src;
                    x_priv_o <= gnt_req.priv;
                    x_rden_o <= ~gnt_req.we;
                    x_wren_o <= gnt_req.we;
                    if (pick_a) begin
                        pend_a <= 1'b0;
                    end else begin
                        pend_b <= 1'b0;
                    end
                end else begin
                    state <= IDLE;
                end
            end

            if (take_a) begin
                pend_a <= 1'b1;
                buf_a  <= req_a;
            end
            if (take_b) begin
                pend_b <= 1'b1;
                buf_b  <= req_b;
            end
        end
    end

endmodule

// File: tb/tb_cellrv32_xbus_arbiter.sv
// tb/tb_cellrv32_xbus_arbiter.sv - bench for cellrv32_xbus_arbiter, fixed-priority and round-robin instances
module tb_cellrv32_xbus_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  ben;
        logic [31:0] wdata;
        logic        src;
        logic        priv;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata, x_rdata;
    logic        a_rden, a_wren, a_src, a_priv;
    logic        b_rden, b_wren, b_src, b_priv;
    logic [3:0]  a_ben, b_ben;
    logic        x_ack, x_err, x_tmo;

    logic [31:0] a_rdata [2];
    logic [31:0] b_rdata [2];
    logic [31:0] x_addr  [2];
    logic [31:0] x_wdata [2];
    logic [3:0]  x_ben   [2];
    logic        a_ack [2], a_err [2], b_ack [2], b_err [2];
    logic        x_rden [2], x_wren [2], x_src [2], x_priv [2], busy [2];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // Instance 0 is fixed priority, instance 1 round-robin; both see the same stimulus.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        cellrv32_xbus_arbiter #(.RR_EN(g == 1)) dut (
            .clk_i(clk), .rst_i(rst),
            .a_addr_i(a_addr), .a_rden_i(a_rden), .a_wren_i(a_wren), .a_ben_i(a_ben),
            .a_data_i(a_wdata), .a_src_i(a_src), .a_priv_i(a_priv),
            .a_data_o(a_rdata[g]), .a_ack_o(a_ack[g]), .a_err_o(a_err[g]),
            .b_addr_i(b_addr), .b_rden_i(b_rden), .b_wren_i(b_wren), .b_ben_i(b_ben),
            .b_data_i(b_wdata), .b_src_i(b_src), .b_priv_i(b_priv),
            .b_data_o(b_rdata[g]), .b_ack_o(b_ack[g]), .b_err_o(b_err[g]),
            .x_addr_o(x_addr[g]), .x_data_o(x_wdata[g]), .x_ben_o(x_ben[g]),
            .x_rden_o(x_rden[g]), .x_wren_o(x_wren[g]), .x_src_o(x_src[g]), .x_priv_o(x_priv[g]),
            .x_data_i(x_rdata), .x_ack_i(x_ack), .x_err_i(x_err), .x_tmo_i(x_tmo),
            .busy_o(busy[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_addr = 0; a_wdata = 0; a_rden = 0; a_wren = 0; a_ben = 0; a_src = 0; a_priv = 0;
        b_addr = 0; b_wdata = 0; b_rden = 0; b_wren = 0; b_ben = 0; b_src = 0; b_priv = 0;
        x_rdata = 0; x_ack = 0; x_err = 0; x_tmo = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if ({a_ack[m], a_err[m], b_ack[m], b_err[m], x_rden[m], x_wren[m], x_src[m], x_priv[m], busy[m], x_ben[m]} !== 13'h0) begin
                errors++;
                $display("FAIL reset_ctl dut%0d: got %h want 0", m,
                         {a_ack[m], a_err[m], b_ack[m], b_err[m], x_rden[m], x_wren[m], x_src[m], x_priv[m], busy[m], x_ben[m]});
            end
            vectors++;
            if ((x_addr[m] | x_wdata[m] | a_rdata[m] | b_rdata[m]) !== 32'h0) begin
                errors++;
                $display("FAIL reset_data dut%0d: got %h want 0", m, x_addr[m] | x_wdata[m] | a_rdata[m] | b_rdata[m]);
            end
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        a_rden = 1; a_addr = 32'h8000_0010;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) begin a_rden = 0; a_addr = 0; end
            x_ack   = (c == 4);
            x_rdata = (c == 4) ? 32'hDEAD_BEEF : 32'h1234_5678;
            @(negedge clk);
            vectors++;
            if (x_rden[0] !== (c == 2) || busy[0] !== (c >= 2 && c <= 4)) begin
                errors++;
                $display("FAIL single_rd_strobe c%0d: got rden=%b busy=%b want rden=%b busy=%b",
                         c, x_rden[0], busy[0], c == 2, (c >= 2 && c <= 4));
            end
            vectors++;
            if ({a_ack[0], a_rdata[0], b_ack[0], a_err[0]} !== {c == 4, (c == 4) ? 32'hDEAD_BEEF : 32'h0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL single_rd_resp c%0d: got ack=%b data=%h back=%b aerr=%b", c, a_ack[0], a_rdata[0], b_ack[0], a_err[0]);
            end
            tick();
        end
        vectors++;
        if (x_addr[0] !== 32'h8000_0010 || x_wren[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_rd_addr: got %h/%b want 80000010/0", x_addr[0], x_wren[0]);
        end
        idle_inputs();
    endtask

    task automatic test_contention();
        do_reset();
        a_wren = 1; a_addr = 32'h0000_0A00; a_wdata = 32'h5555_AAAA; a_ben = 4'hF;
        b_rden = 1; b_addr = 32'h0000_0B00; b_ben = 4'h3;
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        vectors++;
        if ({x_wren[0], x_rden[0], x_addr[0], x_wdata[0], x_ben[0]} !== {1'b1, 1'b0, 32'h0000_0A00, 32'h5555_AAAA, 4'hF}) begin
            errors++;
            $display("FAIL contend_a_grant: got w=%b r=%b addr=%h data=%h ben=%h", x_wren[0], x_rden[0], x_addr[0], x_wdata[0], x_ben[0]);
        end
        tick();
        x_ack = 1;
        @(negedge clk);
        vectors++;
        if ({a_ack[0], b_ack[0], x_rden[0], x_wren[0]} !== 4'b1000) begin
            errors++;
            $display("FAIL contend_a_ack: got %b want 1000", {a_ack[0], b_ack[0], x_rden[0], x_wren[0]});
        end
        tick();
        x_ack = 0;
        @(negedge clk);
        vectors++;
        if ({x_rden[0], busy[0], x_addr[0], x_ben[0]} !== {1'b1, 1'b1, 32'h0000_0B00, 4'h3}) begin
            errors++;
            $display("FAIL contend_b_grant: got r=%b busy=%b addr=%h ben=%h", x_rden[0], busy[0], x_addr[0], x_ben[0]);
        end
        tick();
        x_ack = 1; x_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        vectors++;
        if ({b_ack[0], b_rdata[0], a_ack[0]} !== {1'b1, 32'h0BAD_F00D, 1'b0}) begin
            errors++;
            $display("FAIL contend_b_ack: got back=%b data=%h aack=%b", b_ack[0], b_rdata[0], a_ack[0]);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        int order [4];
        int nserved;
        int served;
        do_reset();
        a_rden = 1; a_addr = 32'h1000_0000;
        b_rden = 1; b_addr = 32'h2000_0000;
        tick();
        nserved = 0;
        for (int c = 0; c < 40 && nserved < 4; c++) begin
            x_ack = 0; a_rden = 0; b_rden = 0;
            if (x_rden[1]) begin
                served = int'(x_addr[1][31:28]);
                order[nserved] = served;
                nserved++;
                x_ack = 1;
                if (served == 1) a_rden = 1;
                else b_rden = 1;
            end
            @(negedge clk);
            tick();
        end
        vectors++;
        if (nserved != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d transfers want 4", nserved);
        end
        for (int i = 0; i < nserved; i++) begin
            vectors++;
            if (order[i] != ((i % 2 == 0) ? 1 : 2)) begin
                errors++;
                $display("FAIL rr_order[%0d]: got port %0d want %0d", i, order[i], (i % 2 == 0) ? 1 : 2);
            end
        end
        idle_inputs();
    endtask

    task automatic test_error();
        do_reset();
        b_rden = 1; b_addr = 32'h0000_0C00;
        tick();
        b_rden = 0;
        tick();
        x_ack = 1; x_err = 1; x_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        vectors++;
        if ({b_err[0], b_ack[0], b_rdata[0], a_err[0], a_ack[0]} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL err_over_ack: got berr=%b back=%b data=%h aerr=%b aack=%b", b_err[0], b_ack[0], b_rdata[0], a_err[0], a_ack[0]);
        end
        tick();
        idle_inputs();
        b_rden = 1; b_addr = 32'h0000_0C04;
        tick();
        b_rden = 0;
        tick();
        x_tmo = 1;
        @(negedge clk);
        vectors++;
        if ({b_err[0], b_ack[0], busy[0]} !== 3'b101) begin
            errors++;
            $display("FAIL tmo_err: got berr=%b back=%b busy=%b want 1 0 1", b_err[0], b_ack[0], busy[0]);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        a_rden = 1; b_rden = 1; a_addr = 32'h0000_0100; b_addr = 32'h0000_0200;
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        vectors++;
        if ({busy[0], x_rden[0]} !== 2'b11) begin
            errors++;
            $display("FAIL rst_flight_pre: got busy=%b rden=%b want 1 1", busy[0], x_rden[0]);
        end
        tick();
        rst = 1;
        @(negedge clk);
        vectors++;
        if ({busy[0], a_ack[0], a_err[0], b_ack[0], b_err[0]} !== 5'b0) begin
            errors++;
            $display("FAIL rst_flight_idle: got %b want 00000", {busy[0], a_ack[0], a_err[0], b_ack[0], b_err[0]});
        end
        tick();
        rst = 0;
        for (int c = 0; c < 4; c++) begin
            x_ack = 1; x_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            vectors++;
            if ({busy[0], x_rden[0], a_ack[0], b_ack[0], a_rdata[0], b_rdata[0]} !== 68'h0) begin
                errors++;
                $display("FAIL rst_flight_after c%0d: got busy=%b rden=%b aack=%b back=%b", c, busy[0], x_rden[0], a_ack[0], b_ack[0]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_spurious_and_repeat();
        int nstrobe;
        int nack;
        do_reset();
        x_ack = 1;
        @(negedge clk);
        vectors++;
        if ({a_ack[0], b_ack[0], a_err[0], b_err[0], busy[0]} !== 5'b0) begin
            errors++;
            $display("FAIL spurious_idle: got %b want 00000", {a_ack[0], b_ack[0], a_err[0], b_err[0], busy[0]});
        end
        tick();
        nstrobe = 0;
        nack = 0;
        for (int c = 0; c < 10; c++) begin
            a_rden = (c < 2);
            a_addr = 32'h0000_0300 + 32'(c);
            x_ack  = (c == 4);
            @(negedge clk);
            if (x_rden[0] || x_wren[0]) nstrobe++;
            if (a_ack[0]) nack++;
            tick();
        end
        vectors++;
        if (nstrobe != 1 || nack != 1) begin
            errors++;
            $display("FAIL repeat_strobe: got %0d transfers %0d acks want 1 1", nstrobe, nack);
        end
        vectors++;
        if (x_addr[0] !== 32'h0000_0300) begin
            errors++;
            $display("FAIL repeat_addr: got %h want 00000300", x_addr[0]);
        end
        idle_inputs();
    endtask

    // Transaction-level reference: one slot per host, one in-service request, last-served port.
    task automatic test_random(input int m, input int ncycles);
        req_t slot [2];
        req_t inreq [2];
        req_t cur;
        bit   has [2];
        bit   strobe [2];
        bit   cap [2];
        int   kind [2];
        int   serving;
        int   last;
        int   pick;
        int   r;
        bit   first;
        bit   done;
        logic e_ack [2];
        logic e_err [2];
        logic [31:0] e_data [2];
        do_reset();
        for (int p = 0; p < 2; p++) begin
            has[p] = 0;
            slot[p] = '0;
        end
        cur = '0; serving = -1; last = 1; first = 0;
        for (int c = 0; c < ncycles; c++) begin
            for (int p = 0; p < 2; p++) begin
                strobe[p] = ($urandom_range(0, 2) == 0);
                kind[p] = $urandom_range(0, 2);
                inreq[p].we = (kind[p] != 0);
                inreq[p].addr = $urandom;
                inreq[p].ben = 4'($urandom);
                inreq[p].wdata = $urandom;
                inreq[p].src = 1'($urandom);
                inreq[p].priv = 1'($urandom);
            end
            a_rden = strobe[0] && kind[0] != 1; a_wren = strobe[0] && kind[0] != 0;
            a_addr = inreq[0].addr; a_ben = inreq[0].ben; a_wdata = inreq[0].wdata;
            a_src = inreq[0].src; a_priv = inreq[0].priv;
            b_rden = strobe[1] && kind[1] != 1; b_wren = strobe[1] && kind[1] != 0;
            b_addr = inreq[1].addr; b_ben = inreq[1].ben; b_wdata = inreq[1].wdata;
            b_src = inreq[1].src; b_priv = inreq[1].priv;
            x_rdata = $urandom; x_ack = 0; x_err = 0; x_tmo = 0;
            if (serving >= 0 && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 5);
                x_ack = (r <= 3); x_err = (r == 2 || r == 4); x_tmo = (r == 3 || r == 5);
            end else if (serving < 0 && $urandom_range(0, 7) == 0) begin
                x_ack = 1; x_err = 1'($urandom);
            end
            for (int p = 0; p < 2; p++) begin
                e_err[p]  = (serving == p) && (x_err || x_tmo);
                e_ack[p]  = (serving == p) && x_ack && !x_err && !x_tmo;
                e_data[p] = e_ack[p] ? x_rdata : 32'h0;
            end
            @(negedge clk);
            vectors++;
            if ({x_rden[m], x_wren[m], x_src[m], x_priv[m], x_ben[m], x_addr[m], x_wdata[m], busy[m]} !==
                {first && !cur.we, first && cur.we, cur.src, cur.priv, cur.ben, cur.addr, cur.wdata, serving >= 0}) begin
                errors++;
                $display("FAIL rand%0d_xside c%0d: got %h want %h", m, c,
                         {x_rden[m], x_wren[m], x_src[m], x_priv[m], x_ben[m], x_addr[m], x_wdata[m], busy[m]},
                         {first && !cur.we, first && cur.we, cur.src, cur.priv, cur.ben, cur.addr, cur.wdata, serving >= 0});
            end
            vectors++;
            if ({a_ack[m], a_err[m], a_rdata[m], b_ack[m], b_err[m], b_rdata[m]} !==
                {e_ack[0], e_err[0], e_data[0], e_ack[1], e_err[1], e_data[1]}) begin
                errors++;
                $display("FAIL rand%0d_host c%0d: got %h want %h", m, c,
                         {a_ack[m], a_err[m], a_rdata[m], b_ack[m], b_err[m], b_rdata[m]},
                         {e_ack[0], e_err[0], e_data[0], e_ack[1], e_err[1], e_data[1]});
            end
            done = (serving >= 0) && (x_ack || x_err || x_tmo);
            for (int p = 0; p < 2; p++)
                cap[p] = strobe[p] && ((!has[p] && serving != p) || (done && serving == p));
            first = 0;
            if (serving < 0 || done) begin
                pick = -1;
                if (has[0] && has[1]) pick = (m == 1) ? (1 - last) : 0;
                else if (has[0]) pick = 0;
                else if (has[1]) pick = 1;
                if (pick >= 0) begin
                    serving = pick; has[pick] = 0; cur = slot[pick]; first = 1; last = pick;
                end else begin
                    serving = -1;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (cap[p]) begin
                    has[p] = 1;
                    slot[p] = inreq[p];
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        test_reset();
        test_single_read();
        test_contention();
        test_round_robin();
        test_error();
        test_reset_inflight();
        test_spurious_and_repeat();
        test_random(0, 400);
        test_random(1, 400);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cellrv32_xbus_arbiter.md
CELLRV32_XBUS_ARBITER -- requirements
Module: cellrv32_xbus_arbiter

Interface
REQ-001 Parameter RR_EN, default 1'b0: 0 = fixed priority (port A wins), 1 = round-robin.
REQ-002 Port prefix <p> denotes either host port a (data, CPU D-side) or b (instruction, CPU I-side); each listed <p> signal exists once per port.
REQ-003 clk_i  input  1  global clock, all state on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 <p>_addr_i  input  32  host access address.
REQ-006 <p>_rden_i  input  1  single-cycle read request strobe.
REQ-007 <p>_wren_i  input  1  single-cycle write request strobe.
REQ-008 <p>_ben_i  input  4  byte enables.
REQ-009 <p>_data_i  input  32  write data.
REQ-010 <p>_src_i / <p>_priv_i  input  1 each  access source (1 = instruction) / privilege (1 = M-mode).
REQ-011 <p>_data_o  output  32  read data, zero unless that port's ack is high.
REQ-012 <p>_ack_o / <p>_err_o  output  1 each  transfer done / transfer failed.
REQ-013 x_addr_o, x_data_o  output  32 each  downstream address / write data.
REQ-014 x_ben_o  output  4  downstream byte enables.
REQ-015 x_rden_o, x_wren_o, x_src_o, x_priv_o  output  1 each  downstream request strobes and tags.
REQ-016 x_data_i  input  32  downstream read data.
REQ-017 x_ack_i, x_err_i, x_tmo_i  input  1 each  downstream ack / bus error / timeout.
REQ-018 busy_o  output  1  high while a downstream transfer is outstanding.

Function
REQ-019 Each port SHALL own a pending buffer (pend flag, we, addr, ben, wdata, src, priv) loaded at the edge ending any cycle with <p>_rden_i or <p>_wren_i high.
REQ-020 If rden and wren are both high, the request SHALL be a write.
REQ-021 A strobe arriving while that port is pending or in service SHALL be ignored, except in the cycle its ack/err is delivered, where it SHALL be captured.
REQ-022 States: IDLE, BUSY_A, BUSY_B; a grant moves to BUSY_<p>, clears pend_<p> and loads the x_* registers from buffer <p>.
REQ-023 Grant SHALL be evaluated in IDLE and in any BUSY cycle that completes; completion with the other port pending SHALL move straight to that BUSY state (no idle bubble).
REQ-024 Arbitration: one requester wins; both pending: RR_EN=0 -> A; RR_EN=1 -> the port not served last (last-served flag resets to B, so A wins first).
REQ-025 x_rden_o/x_wren_o SHALL be high exactly one cycle, the first cycle of BUSY_<p>; x_addr_o, x_data_o, x_ben_o, x_src_o, x_priv_o SHALL hold stable until the next grant.
REQ-026 Latency: strobe in cycle 0 -> x strobe in cycle 2 when idle and uncontended.
REQ-027 Completion in BUSY_<p>: any cycle (including the strobe cycle) with x_ack_i, x_err_i or x_tmo_i high; response routed combinationally to port <p> only.
REQ-028 <p>_err_o = (x_err_i | x_tmo_i) in BUSY_<p>; <p>_ack_o = x_ack_i & ~x_err_i & ~x_tmo_i in BUSY_<p>; error SHALL win over ack.
REQ-029 Responses outside a BUSY state SHALL be ignored and never forwarded.
REQ-030 busy_o SHALL equal (state != IDLE).

Reset
REQ-031 On rst_i: state IDLE, both pend flags 0, last-served = B, all x_* outputs 0, busy_o 0, all host outputs 0; a transfer in flight is abandoned without ack/err.

Verification
REQ-032 a_rden_i, addr 0x8000_0010, cycle 0; x_ack_i cycle 4 with data 0xDEAD_BEEF -> x_rden_o cycle 2 only, a_ack_o and a_data_o = 0xDEAD_BEEF cycle 4, b_ack_o 0.
REQ-033 a_wren_i and b_rden_i same cycle, RR_EN=0 -> A served first, B granted in the cycle of A's ack, x_rden_o for B next cycle.
REQ-034 RR_EN=1, both ports strobe again after each completion, 4 transfers -> service order A,B,A,B.
REQ-035 x_ack_i and x_err_i together in BUSY_B -> b_err_o 1, b_ack_o 0, b_data_o 0; x_tmo_i alone -> b_err_o 1.
REQ-036 rst_i asserted in BUSY_A with B pending -> next cycle IDLE, no ack/err on either port, later x_ack_i ignored.
REQ-037 Spurious x_ack_i in IDLE, and repeated a_rden_i while A pending -> no host ack; second strobe dropped, single downstream transfer.
